// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: sequencer states, reset fetch address,
// PC increment and the redirect-source priority helper.
package cpu_pkg;

  localparam logic [31:0] CPU_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] PC_INC       = 32'd4;
  localparam int          PERF_CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALL    = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_WAIT_MEM = 2'd3
  } pc_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] target;
  } redirect_t;

  // jr outranks jump, which outranks a taken branch.
  function automatic redirect_t pick_redirect(
    input logic        jr_v,
    input logic [31:0] jr_t,
    input logic        jump_v,
    input logic [31:0] jump_t,
    input logic        br_v,
    input logic [31:0] br_t
  );
    redirect_t r;
    r.valid  = jr_v | jump_v | br_v;
    r.target = jr_v ? jr_t : (jump_v ? jump_t : br_t);
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clear wins over inc.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + ONE;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection and IF/ID control for the fetch stage, with a small FSM
// covering load-use stalls, post-redirect bubbles and instruction-memory waits.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = CPU_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  input  logic        imem_ready,
  input  logic        load_use,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic        pc_we,
  output logic        flush_if,
  output logic        stall_id,
  output logic [15:0] redirect_cnt,
  output logic [15:0] stall_cnt
);

  pc_state_e r_state;
  redirect_t r_pend;

  pc_state_e   w_state_next;
  redirect_t   w_pend_next;
  redirect_t   w_redir;
  redirect_t   w_take;
  logic        w_redir_apply;
  logic        w_stall_inc;
  logic [31:0] w_seq_pc;

  assign w_seq_pc = pc_cur + PC_INC;
  assign w_redir  = pick_redirect(jr, jr_target, jump, jump_target, br_taken, br_target);
  // A redirect latched earlier in the wait belongs to an older instruction, so it wins.
  assign w_take   = r_pend.valid ? r_pend : w_redir;

  always_comb begin
    next_pc       = w_seq_pc;
    pc_we         = 1'b1;
    flush_if      = 1'b0;
    stall_id      = 1'b0;
    w_state_next  = ST_RUN;
    w_pend_next   = r_pend;
    w_redir_apply = 1'b0;

    if (reset) begin
      next_pc     = RESET_PC;
      flush_if    = 1'b1;
      w_pend_next = '0;
    end else begin
      case (r_state)
        ST_WAIT_MEM: begin
          w_state_next = ST_WAIT_MEM;
          if (load_use) begin
            pc_we    = 1'b0;
            stall_id = 1'b1;
          end else begin
            if (!r_pend.valid && w_redir.valid) begin
              w_pend_next = w_redir;
            end
            if (imem_ready) begin
              w_pend_next = '0;
              if (w_take.valid) begin
                next_pc       = w_take.target;
                flush_if      = 1'b1;
                w_redir_apply = 1'b1;
                w_state_next  = ST_FLUSH;
              end else begin
                w_state_next = ST_RUN;
              end
            end else begin
              pc_we    = 1'b0;
              flush_if = 1'b1;
            end
          end
        end

        // ID holds a bubble here, so any redirect request is stale.
        ST_FLUSH: begin
          if (load_use) begin
            pc_we        = 1'b0;
            stall_id     = 1'b1;
            w_state_next = ST_STALL;
          end else if (!imem_ready) begin
            pc_we        = 1'b0;
            flush_if     = 1'b1;
            w_state_next = ST_WAIT_MEM;
          end
        end

        // STALL with load_use low is evaluated exactly like RUN.
        default: begin
          if (load_use) begin
            pc_we        = 1'b0;
            stall_id     = 1'b1;
            w_state_next = ST_STALL;
          end else if (w_redir.valid) begin
            next_pc       = w_redir.target;
            flush_if      = 1'b1;
            w_redir_apply = 1'b1;
            w_state_next  = ST_FLUSH;
          end else if (!imem_ready) begin
            pc_we        = 1'b0;
            flush_if     = 1'b1;
            w_state_next = ST_WAIT_MEM;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_next;
      r_pend  <= w_pend_next;
    end
  end

  assign w_stall_inc = stall_id | (r_state == ST_WAIT_MEM);

  sat_counter #(.WIDTH(PERF_CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (w_redir_apply),
    .count (redirect_cnt)
  );

  sat_counter #(.WIDTH(PERF_CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, the fetch address loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port pc_cur, input, 32, the current fetch PC.
REQ-005 SHALL have port imem_ready, input, 1, instruction memory accepted the fetch at pc_cur this cycle.
REQ-006 SHALL have port load_use, input, 1, hazard unit requests a fetch/decode stall.
REQ-007 SHALL have ports br_taken (1) and br_target (32), inputs, a resolved taken branch and its target.
REQ-008 SHALL have ports jump (1) and jump_target (32), inputs, a J/JAL and its target.
REQ-009 SHALL have ports jr (1) and jr_target (32), inputs, a JR and its register target (busA).
REQ-010 SHALL have port next_pc, output, 32, the value the PC register loads at the next edge.
REQ-011 SHALL have port pc_we, output, 1, PC load enable; 0 holds the PC.
REQ-012 SHALL have ports flush_if (1) and stall_id (1), outputs, kill the IF/ID register / hold the IF/ID register.
REQ-013 SHALL have ports redirect_cnt (16) and stall_cnt (16), outputs, saturating performance counters.

Function
REQ-014 SHALL implement the FSM states RUN, STALL, FLUSH, WAIT_MEM, held in a registered state.
REQ-015 SHALL drive next_pc, pc_we, flush_if and stall_id combinationally from the state and current inputs, with zero-cycle latency.
REQ-016 SHALL rank sources in RUN as: load_use > jr > jump > br_taken > sequential (pc_cur + 4, mod 2^32, wrapping FFFF_FFFC to 0).
REQ-017 SHALL, on load_use in RUN or STALL: pc_we=0, stall_id=1, suppress all redirects, and enter or stay in STALL.
REQ-018 SHALL leave STALL for RUN in the first cycle load_use is 0 and evaluate that cycle as RUN.
REQ-019 SHALL, on an accepted redirect (jr/jump/br_taken with load_use=0): set next_pc to the winning target, pc_we=1, flush_if=1, and enter FLUSH.
REQ-020 SHALL ignore jr/jump/br_taken in FLUSH for exactly 1 cycle, because the ID stage holds a bubble; FLUSH performs a sequential update and returns to RUN.
REQ-021 SHALL treat load_use asserted in FLUSH as a stall (stall wins; FSM goes to STALL).
REQ-022 SHALL, when imem_ready=0 in RUN with no load_use or redirect: pc_we=0, flush_if=1, and enter WAIT_MEM.
REQ-023 SHALL hold the PC in WAIT_MEM until imem_ready=1, then update sequentially and return to RUN.
REQ-024 SHALL latch a redirect raised in WAIT_MEM into a 32-bit pending register (priority per REQ-016) and apply it on the imem_ready=1 exit cycle with flush_if=1, entering FLUSH.
REQ-025 SHALL keep pc_we=1 and next_pc=pc_cur+4 in a quiet RUN cycle with imem_ready=1.
REQ-026 SHALL increment redirect_cnt per applied redirect and stall_cnt per cycle with stall_id=1 or in WAIT_MEM; each counter saturates at 16'hFFFF.

Reset
REQ-027 SHALL, while reset=1: state=RUN, next_pc=RESET_PC, pc_we=1, flush_if=1, stall_id=0, pending cleared, both counters 0.
REQ-028 SHALL let reset override all inputs, including mid-stall, mid-WAIT_MEM and a pending redirect.

Structure
REQ-029 SHALL place the state enum, RESET_PC default and the 32'd4 increment constant in shared package cpu_pkg.
REQ-030 SHALL implement the counters as a sub-module sat_counter (width parameter, inc, clear), instantiated twice.

Verification
REQ-031 SHALL cover: reset, then 3 quiet cycles from pc_cur=0x3000 -> next_pc 0x3004/0x3008/0x300C, pc_we=1, flush_if=0 after reset.
REQ-032 SHALL cover: jr=1 (0x4000) with jump=1 and br_taken=1 in one cycle -> next_pc=0x4000, flush_if=1; br_taken next cycle ignored (FLUSH); redirect_cnt=1.
REQ-033 SHALL cover: load_use=1 for 2 cycles with br_taken=1 -> pc_we=0, stall_id=1 for 2 cycles, no redirect; stall_cnt=2; branch taken when load_use drops.
REQ-034 SHALL cover: imem_ready=0 for 3 cycles with jump=1 (0x5000) in the 2nd -> PC held, then next_pc=0x5000 with flush_if=1 on the ready cycle.
REQ-035 SHALL cover: reset asserted in WAIT_MEM with a pending redirect -> next cycle next_pc=0x3000, state RUN, pending and counters cleared.
REQ-036 SHALL cover: pc_cur=0xFFFF_FFFC quiet -> next_pc=0x0000_0000; stall_cnt driven past 0xFFFF -> holds 0xFFFF.
